// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned UART_BIT_RATE = 9600;
    localparam int unsigned UART_CLK_HZ   = 50000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                   input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the receive pin plus a delay flop for falling-edge detection.
module uart_rx_sync (
    input  logic clk,
    input  logic resetn,
    input  logic rxd,
    output logic level,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic dly_q, dly_d;

    always_comb begin
        s1_d  = rxd;
        s2_d  = s1_q;
        dly_d = s2_q;
    end

    // Reset to 1 so an idle-high line never looks like a start edge out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_q  <= 1'b1;
            s2_q  <= 1'b1;
            dly_q <= 1'b1;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            dly_q <= dly_d;
        end
    end

    assign level = s2_q;
    assign fall  = ~s2_q & dly_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: start-edge detect, mid-bit sampling, registered valid/error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BIT_RATE     = UART_BIT_RATE,
    parameter int unsigned CLK_HZ       = UART_CLK_HZ,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break
);

    localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int unsigned CNT_W          = $clog2(CYCLES_PER_BIT + 1);
    localparam int unsigned IDX_W          = $clog2(PAYLOAD_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAYLOAD_BITS - 1);

    uart_rx_state_t          state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    stop_idx_q, stop_idx_d;
    logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    brk_q, brk_d;
    logic                    rx_level;
    logic                    rx_fall;

    uart_rx_sync u_sync (
        .clk    (clk),
        .resetn (resetn),
        .rxd    (uart_rxd),
        .level  (rx_level),
        .fall   (rx_fall)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        brk_d      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                idx_d      = '0;
                stop_idx_d = 1'b0;
                if (rx_fall && uart_rx_en) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_level ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_level, shreg_q[PAYLOAD_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!rx_level) begin
                        ferr_d  = 1'b1;
                        brk_d   = (shreg_q == '0);
                        state_d = IDLE;
                    end else if (STOP_BITS > 1 && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
        end
    end

    assign uart_rx_valid     = valid_q;
    assign uart_rx_data      = data_q;
    assign uart_rx_frame_err = ferr_q;
    assign uart_rx_break     = brk_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous UART receiver, the receive-side counterpart of `uart_tx`, using the same parameters and line format: 8N1, LSB first, idle high. It synchronises the external `uart_rxd` pin and detects the start bit. Each bit is sampled at mid-bit using a cycle counter. Each received byte is presented as a one-cycle `valid` pulse, with framing-error and break indications.

## Interface
- `BIT_RATE`, default 9600: line bit rate in bit/s.
- `CLK_HZ`, default 50000000: system clock frequency in Hz.
- `PAYLOAD_BITS`, default 8: data bits per frame.
- `STOP_BITS`, default 1: stop bits checked per frame (1 or 2).
- `clk` input, 1 bit: system clock, single clock domain.
- `resetn` input, 1 bit: reset, asynchronous, active-low.
- `uart_rxd` input, 1 bit: UART receive pin, asynchronous to `clk`.
- `uart_rx_en` input, 1 bit: receiver enable; sampled only in IDLE.
- `uart_rx_valid` output, 1 bit: one-cycle pulse when a good frame completes.
- `uart_rx_data` output, `PAYLOAD_BITS` bits: last good byte; held until the next good frame.
- `uart_rx_frame_err` output, 1 bit: one-cycle pulse when a stop bit is sampled low.
- `uart_rx_break` output, 1 bit: one-cycle pulse when the data is all zero and the stop bit is low; `frame_err` pulses in the same cycle.

## Operation
- `CYCLES_PER_BIT` = `CLK_HZ/BIT_RATE`, integer division (5208 at defaults). `HALF_BIT` = `CYCLES_PER_BIT/2` (2604).
- Bit counter width is `$clog2(CYCLES_PER_BIT+1)`. Bit index counter width is `$clog2(PAYLOAD_BITS+1)`.
- Input path: 2-flop synchroniser, reset value 1, followed by one delay flop. A falling edge is when the synchronised value is 0 and the delayed copy is 1.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Counter is 0.
  - On a falling edge with `uart_rx_en`=1, go to START.
  - With `uart_rx_en`=0, edges are ignored.
- START:
  - Count to `HALF_BIT`-1, then sample the line.
  - Line 0: go to DATA and clear the counter.
  - Line 1: false start, return to IDLE with no output pulse.
- DATA:
  - Every `CYCLES_PER_BIT` cycles, sample the line and shift it into the MSB of the shift register. After `PAYLOAD_BITS` shifts the first bit received sits in bit 0.
  - After the last bit, go to STOP.
- STOP:
  - After `CYCLES_PER_BIT` cycles, sample the line.
  - Line 1 with `STOP_BITS`=1: load `uart_rx_data` from the shift register, pulse `uart_rx_valid`, go to IDLE.
  - Line 1 with `STOP_BITS`=2: repeat the stop sample once more before completing.
  - Line 0: pulse `uart_rx_frame_err`. If the shift register is all zero, also pulse `uart_rx_break`. `uart_rx_data` is not updated. Go to IDLE.
- After a frame error, re-arming requires the line to return high, because edge detection needs a 1-to-0 transition.
- Deasserting `uart_rx_en` mid-frame has no effect; the frame completes normally.
- `resetn` low at any time, including mid-frame: FSM goes to IDLE, counters and shift register clear, all outputs return to reset values, synchroniser flops go to 1.

## Timing
- Reset values:
  - `uart_rx_valid` = 0
  - `uart_rx_frame_err` = 0
  - `uart_rx_break` = 0
  - `uart_rx_data` = 0
- Latency, measured from the first `clk` edge that samples `uart_rxd`=0 to `uart_rx_valid` high: L = 3 + `HALF_BIT` + (`PAYLOAD_BITS`+`STOP_BITS`)·`CYCLES_PER_BIT` cycles. This is 49479 at defaults.
- `uart_rx_data` changes in the same cycle `uart_rx_valid` is high and holds thereafter.
- Back-to-back frames: the next start edge arrives about half a bit after the stop sample. IDLE is re-entered one cycle after the stop sample, so no frame is lost.
- Pulses are exactly one cycle and registered. There is no combinational path from `uart_rxd` to any output.

## Structure
- Shared package `uart_pkg`, also used by `uart_tx`, holds:
  - `uart_rx_state_t` enum: IDLE, START, DATA, STOP.
  - Function `cycles_per_bit(clk_hz, bit_rate)`.
  - Localparam defaults `UART_BIT_RATE` = 9600 and `UART_CLK_HZ` = 50000000.
- One sub-module, `uart_rx_sync`: 2-flop synchroniser plus edge detect. It outputs the synchronised level and a `fall` strobe, with asynchronous active-low reset to 1.

## Test plan
- Sequential bytes 0xA5, 0x3C, 0xFF sent back-to-back at 9600 with a 50 MHz clock:
  - Three `uart_rx_valid` pulses with data A5, 3C, FF.
  - First pulse arrives 49479 cycles after the start edge.
- 1 µs low glitch on an idle line: no output pulse, FSM back in IDLE within `HALF_BIT`+3 cycles.
- Frame 0x5A with stop bit driven low: `uart_rx_frame_err` pulses, `uart_rx_valid` stays 0, `uart_rx_data` keeps its previous value.
- Line held low for 12 bit periods (break):
  - `uart_rx_break` and `uart_rx_frame_err` pulse together once.
  - No further pulse until the line returns high and a new start bit is sent.
- `resetn` pulsed low during bit 4 of 0xC3:
  - All outputs read 0 immediately.
  - A following 0x81 frame is received correctly.
- Loopback from `uart_tx` with 10 `$random` bytes: every `uart_rx_data` matches the sent byte in order, with zero `frame_err` pulses.
